// File: rtl/usb_sie_tx.sv
// USB SIE transmit framer: sends PID, payload and a generated CRC16 over the UTMI
// transmit interface, keeping tx_valid continuous for the whole packet.
module usb_sie_tx #(
   parameter bit CHECK_PID = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       req_valid,
   input  logic [3:0] req_pid,
   input  logic       req_zlp,
   output logic       req_ready,
   input  logic [7:0] pld_data,
   input  logic       pld_valid,
   input  logic       pld_last,
   output logic       pld_ready,
   output logic       busy,
   output logic       tx_err,
   output logic [7:0] data_in,
   output logic       tx_valid,
   input  logic       tx_ready
);

   localparam logic [3:0] PidAck   = 4'b0010;
   localparam logic [3:0] PidNak   = 4'b1010;
   localparam logic [3:0] PidStall = 4'b1110;
   localparam logic [3:0] PidData0 = 4'b0011;
   localparam logic [3:0] PidData1 = 4'b1011;

   typedef enum logic [2:0] {StIdle, StPid, StData, StCrcLo, StCrcHi} state_t;

   state_t      state_q, state_d;
   logic [3:0]  pid_q, pid_d;
   logic        zlp_q, zlp_d;
   logic [15:0] crc_q, crc_d;
   logic [15:0] crc_next;
   logic [7:0]  data_q, data_d;
   logic        tx_valid_q, tx_valid_d;
   logic        busy_q, busy_d;
   logic        req_ready_q, req_ready_d;
   logic        tx_err_q, tx_err_d;
   logic        req_is_data, req_legal, pid_is_data;

   // Reflected CRC16 (poly 0xA001), one byte LSB first.
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      c = crc ^ {8'h00, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
      end
      return c;
   endfunction

   assign req_is_data = (req_pid == PidData0) || (req_pid == PidData1);
   assign req_legal   = req_is_data || (req_pid == PidAck) || (req_pid == PidNak) ||
                        (req_pid == PidStall);
   // Unlisted PIDs accepted with CHECK_PID=0 go out as single-byte packets.
   assign pid_is_data = (pid_q == PidData0) || (pid_q == PidData1);
   assign crc_next    = crc16_byte(crc_q, pld_data);

   always_comb begin
      state_d    = state_q;
      pid_d      = pid_q;
      zlp_d      = zlp_q;
      crc_d      = crc_q;
      data_d     = data_q;
      tx_valid_d = tx_valid_q;
      busy_d     = busy_q;
      tx_err_d   = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (req_valid && req_ready_q) begin
               if (req_legal || !CHECK_PID) begin
                  pid_d      = req_pid;
                  zlp_d      = req_zlp;
                  crc_d      = 16'hFFFF;
                  data_d     = {~req_pid, req_pid};
                  tx_valid_d = 1'b1;
                  busy_d     = 1'b1;
                  state_d    = StPid;
               end else begin
                  tx_err_d = 1'b1;
               end
            end
         end
         StPid: begin
            if (tx_ready) begin
               if (!pid_is_data) begin
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  state_d    = StIdle;
               end else if (zlp_q) begin
                  data_d  = ~crc_q[7:0];
                  state_d = StCrcLo;
               end else begin
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (tx_ready) begin
               if (pld_valid) begin
                  crc_d = crc_next;
                  if (pld_last) begin
                     data_d  = ~crc_next[7:0];
                     state_d = StCrcLo;
                  end
               end else begin
                  // Underrun: dropping tx_valid makes the UTM close the packet early.
                  tx_err_d   = 1'b1;
                  tx_valid_d = 1'b0;
                  busy_d     = 1'b0;
                  state_d    = StIdle;
               end
            end
         end
         StCrcLo: begin
            if (tx_ready) begin
               data_d  = ~crc_q[15:8];
               state_d = StCrcHi;
            end
         end
         StCrcHi: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               busy_d     = 1'b0;
               state_d    = StIdle;
            end
         end
         default: begin
            tx_valid_d = 1'b0;
            busy_d     = 1'b0;
            state_d    = StIdle;
         end
      endcase

      req_ready_d = (state_d == StIdle);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         pid_q       <= 4'h0;
         zlp_q       <= 1'b0;
         crc_q       <= 16'hFFFF;
         data_q      <= 8'h00;
         tx_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         req_ready_q <= 1'b0;
         tx_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         pid_q       <= pid_d;
         zlp_q       <= zlp_d;
         crc_q       <= crc_d;
         data_q      <= data_d;
         tx_valid_q  <= tx_valid_d;
         busy_q      <= busy_d;
         req_ready_q <= req_ready_d;
         tx_err_q    <= tx_err_d;
      end
   end

   assign req_ready = req_ready_q;
   assign busy      = busy_q;
   assign tx_err    = tx_err_q;
   assign tx_valid  = tx_valid_q;
   assign data_in   = (state_q == StData) ? pld_data : data_q;
   assign pld_ready = (state_q == StData) && tx_ready && pld_valid;

endmodule

// File: tb/tb_usb_sie_tx.sv
// Directed bench for usb_sie_tx: table of packet requests checked against a
// byte/CRC model, plus hand sequences for illegal PID, underrun and reset.
module tb_usb_sie_tx;

   logic       clk, rst;
   logic       req_valid, req_zlp, req_ready;
   logic [3:0] req_pid;
   logic [7:0] pld_data, data_in;
   logic       pld_valid, pld_last, pld_ready;
   logic       busy, tx_err, tx_valid, tx_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] pid;
      bit         zlp;
      int         len;
      bit         rnd;
      logic [7:0] seed;
      logic [7:0] exp_first;
      int         exp_n;
      int         exp_pulses;
   } vec_t;

   vec_t vecs[7];

   usb_sie_tx #(.CHECK_PID(1'b1)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_pid   (req_pid),
      .req_zlp   (req_zlp),
      .req_ready (req_ready),
      .pld_data  (pld_data),
      .pld_valid (pld_valid),
      .pld_last  (pld_last),
      .pld_ready (pld_ready),
      .busy      (busy),
      .tx_err    (tx_err),
      .data_in   (data_in),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [15:0] model_crc(input logic [15:0] crc, input logic [7:0] b);
      logic [15:0] c;
      logic        fb;
      c = crc;
      for (int j = 0; j < 8; j++) begin
         fb = c[0] ^ b[j];
         c  = c >> 1;
         if (fb) c = c ^ 16'hA001;
      end
      return c;
   endfunction

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req_ready) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic run_packet(input int vi, input vec_t v);
      logic [7:0]  got[$];
      logic [7:0]  expq[$];
      logic [15:0] crc, res;
      logic [7:0]  prev;
      int          idx, pulses, viol, errs;
      bit          ok, done, hold, is_data;
      string       tag;
      tag = $sformatf("v%0d", vi);
      idx = 0; pulses = 0; viol = 0; errs = 0; done = 0; hold = 0; prev = 8'h00;
      is_data = (v.pid == 4'b0011) || (v.pid == 4'b1011);
      expq.push_back({~v.pid, v.pid});
      if (is_data) begin
         crc = 16'hFFFF;
         for (int i = 0; i < v.len; i++) begin
            expq.push_back(v.seed + 8'(i));
            crc = model_crc(crc, v.seed + 8'(i));
         end
         expq.push_back(~crc[7:0]);
         expq.push_back(~crc[15:8]);
      end
      wait_ready(ok);
      check({tag, "_req_ready"}, 32'(ok), 32'd1);
      if (!ok) return;
      req_valid = 1'b1; req_pid = v.pid; req_zlp = v.zlp;
      @(posedge clk); #1;
      req_valid = 1'b0;
      for (int c = 0; c < 1000 && !done; c++) begin
         tx_ready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         pld_valid = (idx < v.len);
         pld_data  = v.seed + 8'(idx);
         pld_last  = (idx == v.len - 1);
         @(negedge clk);
         if (!tx_valid) begin
            done = 1'b1;
         end else begin
            if (hold && data_in !== prev) viol++;
            if (!busy || req_ready) viol++;
            if (tx_err) errs++;
            if (tx_ready) got.push_back(data_in);
            if (pld_ready) begin idx++; pulses++; end
            hold = !tx_ready;
            prev = data_in;
            @(posedge clk); #1;
         end
      end
      pld_valid = 1'b0; pld_last = 1'b0;
      check({tag, "_ended"}, 32'(done), 32'd1);
      check({tag, "_busy_end"}, 32'(busy), 32'd0);
      check({tag, "_req_ready_end"}, 32'(req_ready), 32'd1);
      check({tag, "_nbytes"}, 32'(got.size()), 32'(v.exp_n));
      check({tag, "_nbytes_model"}, 32'(got.size()), 32'(expq.size()));
      if (got.size() > 0) check({tag, "_first"}, 32'(got[0]), 32'(v.exp_first));
      for (int i = 0; i < got.size() && i < expq.size(); i++)
         check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(expq[i]));
      check({tag, "_pld_pulses"}, 32'(pulses), 32'(v.exp_pulses));
      check({tag, "_hold_viol"}, 32'(viol), 32'd0);
      check({tag, "_tx_err"}, 32'(errs), 32'd0);
      if (is_data && got.size() > 1) begin
         crc = 16'hFFFF;
         for (int i = 1; i < got.size(); i++) crc = model_crc(crc, got[i]);
         for (int b = 0; b < 16; b++) res[b] = crc[15-b];
         check({tag, "_residual"}, 32'(res), 32'h800D);
      end
   endtask

   initial begin
      bit ok, reached;
      int idx;
      vecs[0] = '{4'b0010, 1'b0, 0,  1'b0, 8'h00, 8'hD2, 1,  0};
      vecs[1] = '{4'b1010, 1'b1, 0,  1'b0, 8'h00, 8'h5A, 1,  0};
      vecs[2] = '{4'b1110, 1'b0, 0,  1'b1, 8'h00, 8'h1E, 1,  0};
      vecs[3] = '{4'b0011, 1'b1, 0,  1'b0, 8'h00, 8'hC3, 3,  0};
      vecs[4] = '{4'b1011, 1'b0, 4,  1'b0, 8'h00, 8'h4B, 7,  4};
      vecs[5] = '{4'b0011, 1'b0, 64, 1'b1, 8'h40, 8'hC3, 67, 64};
      vecs[6] = '{4'b1011, 1'b0, 1,  1'b1, 8'hA5, 8'h4B, 4,  1};

      rst = 1'b1; req_valid = 1'b0; req_pid = 4'h0; req_zlp = 1'b0;
      pld_data = 8'h00; pld_valid = 1'b0; pld_last = 1'b0; tx_ready = 1'b0;
      #2;
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_pld_ready", 32'(pld_ready), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_tx_err", 32'(tx_err), 32'd0);
      check("rst_tx_valid", 32'(tx_valid), 32'd0);
      check("rst_data_in", 32'(data_in), 32'h00);
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_req_ready", 32'(req_ready), 32'd1);

      for (int i = 0; i < 7; i++) run_packet(i, vecs[i]);

      // Illegal PID: rejected with a tx_err pulse, nothing transmitted.
      wait_ready(ok);
      check("ill_req_ready", 32'(ok), 32'd1);
      req_valid = 1'b1; req_pid = 4'b0001; req_zlp = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("ill_tx_err", 32'(tx_err), 32'd1);
      check("ill_tx_valid", 32'(tx_valid), 32'd0);
      check("ill_busy", 32'(busy), 32'd0);
      check("ill_req_ready_after", 32'(req_ready), 32'd1);
      @(negedge clk);
      check("ill_tx_err_once", 32'(tx_err), 32'd0);
      check("ill_tx_valid2", 32'(tx_valid), 32'd0);

      // Underrun: payload stalls on byte 3 while the UTM is ready.
      wait_ready(ok);
      check("ur_req_ready", 32'(ok), 32'd1);
      req_valid = 1'b1; req_pid = 4'b1011; req_zlp = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      idx = 0; reached = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tx_ready = 1'b1;
         if (idx == 3) begin
            pld_valid = 1'b0;
            reached   = 1'b1;
         end else begin
            pld_valid = 1'b1;
            pld_data  = 8'h10 + 8'(idx);
            pld_last  = 1'b0;
         end
         @(negedge clk);
         if (reached) break;
         if (pld_ready) idx++;
         @(posedge clk); #1;
      end
      check("ur_reached", 32'(reached), 32'd1);
      check("ur_stall_pld_ready", 32'(pld_ready), 32'd0);
      check("ur_stall_tx_valid", 32'(tx_valid), 32'd1);
      check("ur_stall_tx_err", 32'(tx_err), 32'd0);
      @(posedge clk); #1;
      pld_valid = 1'b1;
      @(negedge clk);
      check("ur_tx_err", 32'(tx_err), 32'd1);
      check("ur_tx_valid", 32'(tx_valid), 32'd0);
      check("ur_busy", 32'(busy), 32'd0);
      check("ur_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      pld_valid = 1'b0;
      @(negedge clk);
      check("ur_tx_err_once", 32'(tx_err), 32'd0);
      run_packet(7, vecs[0]);

      // Asynchronous reset in the middle of a payload.
      wait_ready(ok);
      check("rs_req_ready", 32'(ok), 32'd1);
      req_valid = 1'b1; req_pid = 4'b0011; req_zlp = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      idx = 0; reached = 1'b0;
      for (int c = 0; c < 50; c++) begin
         tx_ready = 1'b1; pld_valid = 1'b1; pld_data = 8'(idx); pld_last = 1'b0;
         @(negedge clk);
         if (pld_ready) idx++;
         if (idx == 2) begin
            reached = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
      check("rs_reached", 32'(reached), 32'd1);
      check("rs_pre_tx_valid", 32'(tx_valid), 32'd1);
      check("rs_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rs_tx_valid", 32'(tx_valid), 32'd0);
      check("rs_busy", 32'(busy), 32'd0);
      check("rs_req_ready", 32'(req_ready), 32'd0);
      check("rs_data_in", 32'(data_in), 32'h00);
      check("rs_pld_ready", 32'(pld_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0; pld_valid = 1'b0; tx_ready = 1'b0;
      run_packet(8, vecs[4]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
